// File: rtl/vga_pkg.sv
// Shared VGA constants, colour/state types and the per-axis bounce step.
package vga_pkg;

  localparam int unsigned H_DISPLAY = 640;
  localparam int unsigned V_DISPLAY = 480;

  typedef logic [11:0] rgb_t;

  localparam rgb_t BG_COLOUR = 12'h111;

  localparam rgb_t PALETTE [8] = '{
    12'hF00, 12'h0F0, 12'h00F, 12'hFF0,
    12'h0FF, 12'hF0F, 12'hF80, 12'hFFF
  };

  typedef enum logic [1:0] {
    StInit,
    StRun,
    StHold
  } state_t;

  // Direction encoding: positive means right (x) or down (y).
  localparam logic DirPos = 1'b0;
  localparam logic DirNeg = 1'b1;

  typedef struct packed {
    logic [9:0] pos;
    logic       dir;
    logic       bounce;
  } axis_t;

  // One frame step on one axis; 11-bit arithmetic so neither edge can wrap.
  function automatic axis_t step_axis(input logic [9:0]  pos,
                                      input logic        dir,
                                      input logic [2:0]  speed,
                                      input logic [10:0] bound);
    axis_t       r;
    logic [10:0] pos_w;
    logic [10:0] spd_w;
    logic [10:0] sum;
    pos_w    = {1'b0, pos};
    spd_w    = {8'd0, speed};
    r.pos    = pos;
    r.dir    = dir;
    r.bounce = 1'b0;
    if (dir == DirPos) begin
      sum = pos_w + spd_w;
      if (sum > bound) begin
        r.pos    = bound[9:0];
        r.dir    = DirNeg;
        r.bounce = 1'b1;
      end else begin
        r.pos = sum[9:0];
      end
    end else begin
      sum = pos_w - spd_w;
      if (pos_w < spd_w) begin
        r.pos    = '0;
        r.dir    = DirPos;
        r.bounce = 1'b1;
      end else begin
        r.pos = sum[9:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/pipe_delay.sv
// Fixed-depth shift delay with asynchronous reset to a chosen value.
module pipe_delay #(
  parameter int unsigned             WIDTH     = 1,
  parameter int unsigned             DEPTH     = 2,
  parameter logic [WIDTH-1:0]        RESET_VAL = '0
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];

  // Each stage takes the previous one; stage 0 takes the input.
  always_comb begin
    stage_d[0] = d_i;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  // Shift register, cleared to the inactive value on reset.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= RESET_VAL;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/bounce_box_gen.sv
// Bouncing square overlay for a 640x480 VGA timing stream.
// Motion updates once per frame in vertical blanking; pixel path is two stages.
module bounce_box_gen
  import vga_pkg::*;
#(
  parameter int unsigned BOX_SIZE = 32,
  parameter int unsigned X0       = 304,
  parameter int unsigned Y0       = 224
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        hsync_ni,
  input  logic        vsync_ni,
  input  logic        display_enable_i,
  input  logic [9:0]  hpos_i,
  input  logic [9:0]  vpos_i,
  input  logic        pause_i,
  input  logic [2:0]  speed_i,
  output logic        hsync_no,
  output logic        vsync_no,
  output logic [11:0] rgb_o
);

  localparam logic [10:0] XBound = 11'(H_DISPLAY - BOX_SIZE);
  localparam logic [10:0] YBound = 11'(V_DISPLAY - BOX_SIZE);
  localparam logic [10:0] Size   = 11'(BOX_SIZE);

  state_t     state_q, state_d;
  logic [9:0] box_x_q, box_x_d, box_y_q, box_y_d;
  logic       dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic [2:0] pal_idx_q, pal_idx_d;

  logic  frame_tick;
  axis_t ax, ay;

  // First line of vertical blanking: the box never moves during a visible frame.
  assign frame_tick = (vpos_i == 10'(V_DISPLAY)) && (hpos_i == 10'd0);

  assign ax = step_axis(box_x_q, dir_x_q, speed_i, XBound);
  assign ay = step_axis(box_y_q, dir_y_q, speed_i, YBound);

  // Next motion state; only a tick seen while already running moves the box.
  always_comb begin
    state_d   = state_q;
    box_x_d   = box_x_q;
    box_y_d   = box_y_q;
    dir_x_d   = dir_x_q;
    dir_y_d   = dir_y_q;
    pal_idx_d = pal_idx_q;
    if (frame_tick) begin
      unique case (state_q)
        StInit: state_d = StRun;
        StRun: begin
          box_x_d = ax.pos;
          box_y_d = ay.pos;
          dir_x_d = ax.dir;
          dir_y_d = ay.dir;
          // A corner hit counts as a single bounce.
          if (ax.bounce || ay.bounce) pal_idx_d = pal_idx_q + 3'd1;
          if (pause_i) state_d = StHold;
        end
        StHold: if (!pause_i) state_d = StRun;
        default: state_d = StInit;
      endcase
    end
  end

  // Motion FSM and box registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= StInit;
      box_x_q   <= 10'(X0);
      box_y_q   <= 10'(Y0);
      dir_x_q   <= DirPos;
      dir_y_q   <= DirPos;
      pal_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      box_x_q   <= box_x_d;
      box_y_q   <= box_y_d;
      dir_x_q   <= dir_x_d;
      dir_y_q   <= dir_y_d;
      pal_idx_q <= pal_idx_d;
    end
  end

  logic inside_q, inside_d;
  logic de_q;
  rgb_t rgb_q, rgb_d;

  // Stage 1 compare: half-open box [pos, pos+BOX_SIZE) on both axes.
  always_comb begin
    inside_d = ({1'b0, hpos_i} >= {1'b0, box_x_q}) &&
               ({1'b0, hpos_i} <  ({1'b0, box_x_q} + Size)) &&
               ({1'b0, vpos_i} >= {1'b0, box_y_q}) &&
               ({1'b0, vpos_i} <  ({1'b0, box_y_q} + Size));
  end

  // Stage 2 colour mux.
  always_comb begin
    rgb_d = '0;
    if (de_q) rgb_d = inside_q ? PALETTE[pal_idx_q] : BG_COLOUR;
  end

  // Pixel pipeline registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      inside_q <= 1'b0;
      de_q     <= 1'b0;
      rgb_q    <= '0;
    end else begin
      inside_q <= inside_d;
      de_q     <= display_enable_i;
      rgb_q    <= rgb_d;
    end
  end

  logic [1:0] sync_dly;

  pipe_delay #(
    .WIDTH    (2),
    .DEPTH    (2),
    .RESET_VAL(2'b11)
  ) u_sync_dly (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .d_i    ({hsync_ni, vsync_ni}),
    .q_o    (sync_dly)
  );

  assign hsync_no = sync_dly[1];
  assign vsync_no = sync_dly[0];
  assign rgb_o    = rgb_q;

endmodule

// File: tb/tb_bounce_box_gen.sv
// Directed bench: three instances (default, edge/corner start, fixed pixel box).
module tb_bounce_box_gen;
  import vga_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] hpos, vpos;
  logic       de, hs_n, vs_n;
  logic       pause_a;
  logic [2:0] speed_a, speed_b;

  logic        hs_a, vs_a, hs_b, vs_b, hs_c, vs_c;
  logic [11:0] rgb_a, rgb_b, rgb_c;

  int unsigned n_checks = 0;
  int unsigned n_err    = 0;

  // Bench-side copy of the expected colours.
  localparam logic [11:0] ExpPal0 = 12'hF00;
  localparam logic [11:0] ExpPal3 = 12'hFF0;
  localparam logic [11:0] ExpBg   = 12'h111;

  always #5 clk = ~clk;

  bounce_box_gen dut_a (
    .clk_i(clk), .reset_i(reset), .hsync_ni(hs_n), .vsync_ni(vs_n),
    .display_enable_i(de), .hpos_i(hpos), .vpos_i(vpos), .pause_i(pause_a),
    .speed_i(speed_a), .hsync_no(hs_a), .vsync_no(vs_a), .rgb_o(rgb_a)
  );

  bounce_box_gen #(.X0(606), .Y0(288)) dut_b (
    .clk_i(clk), .reset_i(reset), .hsync_ni(hs_n), .vsync_ni(vs_n),
    .display_enable_i(de), .hpos_i(hpos), .vpos_i(vpos), .pause_i(1'b0),
    .speed_i(speed_b), .hsync_no(hs_b), .vsync_no(vs_b), .rgb_o(rgb_b)
  );

  bounce_box_gen #(.X0(100), .Y0(50)) dut_c (
    .clk_i(clk), .reset_i(reset), .hsync_ni(hs_n), .vsync_ni(vs_n),
    .display_enable_i(de), .hpos_i(hpos), .vpos_i(vpos), .pause_i(1'b0),
    .speed_i(3'd0), .hsync_no(hs_c), .vsync_no(vs_c), .rgb_o(rgb_c)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    hpos = 10'd5; vpos = 10'd481; de = 1'b0; hs_n = 1'b1; vs_n = 1'b1;
  endtask

  // One-cycle frame tick; state has updated when this returns.
  task automatic tick();
    @(posedge clk); #1;
    hpos = 10'd0; vpos = 10'd480; de = 1'b0;
    @(posedge clk); #1;
    idle();
  endtask

  task automatic ticks_b(input int n, input logic [2:0] spd);
    speed_b = spd;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check_box_a(input string name, input int x, input int y);
    check({name, ".x"}, 32'(dut_a.box_x_q), 32'(x));
    check({name, ".y"}, 32'(dut_a.box_y_q), 32'(y));
  endtask

  task automatic check_box_b(input string name, input int x, input int y,
                             input logic dx, input logic dy, input int idx);
    check({name, ".x"},   32'(dut_b.box_x_q),   32'(x));
    check({name, ".y"},   32'(dut_b.box_y_q),   32'(y));
    check({name, ".dx"},  32'(dut_b.dir_x_q),   32'(dx));
    check({name, ".dy"},  32'(dut_b.dir_y_q),   32'(dy));
    check({name, ".idx"}, 32'(dut_b.pal_idx_q), 32'(idx));
  endtask

  typedef struct {
    logic [9:0]  h;
    logic [9:0]  v;
    logic        de;
    logic        hs;
    logic        vs;
    logic [11:0] exp_a;
    logic [11:0] exp_c;
  } vec_t;

  vec_t vecs [12];

  initial begin
    // A box at (304,224), C box at (100,50), both palette index 0.
    vecs[0]  = '{10'd100, 10'd50,  1'b1, 1'b1, 1'b1, ExpBg,   ExpPal0};
    vecs[1]  = '{10'd132, 10'd50,  1'b1, 1'b0, 1'b1, ExpBg,   ExpBg};
    vecs[2]  = '{10'd131, 10'd81,  1'b1, 1'b1, 1'b0, ExpBg,   ExpPal0};
    vecs[3]  = '{10'd99,  10'd50,  1'b1, 1'b0, 1'b0, ExpBg,   ExpBg};
    vecs[4]  = '{10'd100, 10'd82,  1'b1, 1'b1, 1'b1, ExpBg,   ExpBg};
    vecs[5]  = '{10'd100, 10'd49,  1'b1, 1'b0, 1'b1, ExpBg,   ExpBg};
    vecs[6]  = '{10'd304, 10'd224, 1'b1, 1'b1, 1'b0, ExpPal0, ExpBg};
    vecs[7]  = '{10'd335, 10'd255, 1'b1, 1'b1, 1'b1, ExpPal0, ExpBg};
    vecs[8]  = '{10'd336, 10'd224, 1'b1, 1'b0, 1'b0, ExpBg,   ExpBg};
    vecs[9]  = '{10'd304, 10'd256, 1'b1, 1'b1, 1'b1, ExpBg,   ExpBg};
    vecs[10] = '{10'd700, 10'd50,  1'b0, 1'b0, 1'b1, 12'h000, 12'h000};
    vecs[11] = '{10'd100, 10'd50,  1'b0, 1'b1, 1'b0, 12'h000, 12'h000};

    // Reset with syncs driven active so the inactive reset value is visible.
    reset = 1'b1; pause_a = 1'b0; speed_a = 3'd0; speed_b = 3'd0;
    idle(); hs_n = 1'b0; vs_n = 1'b0; de = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst.rgb", 32'(rgb_a), 32'h0);
    check("rst.hs",  32'(hs_a),  32'h1);
    check("rst.vs",  32'(vs_a),  32'h1);
    check_box_a("rst", 304, 224);
    check("rst.state", 32'(dut_a.state_q), 32'(StInit));
    check("rst.idx",   32'(dut_a.pal_idx_q), 32'h0);
    idle();
    reset = 1'b0;

    // Pixel stream: each output is compared with the vector applied two cycles earlier.
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1;
      if (i >= 2) begin
        check($sformatf("pix%0d.a", i-2),  32'(rgb_a), 32'(vecs[i-2].exp_a));
        check($sformatf("pix%0d.c", i-2),  32'(rgb_c), 32'(vecs[i-2].exp_c));
        check($sformatf("pix%0d.hs", i-2), 32'(hs_a),  32'(vecs[i-2].hs));
        check($sformatf("pix%0d.vs", i-2), 32'(vs_a),  32'(vecs[i-2].vs));
      end
      if (i < 12) begin
        hpos = vecs[i].h; vpos = vecs[i].v; de = vecs[i].de;
        hs_n = vecs[i].hs; vs_n = vecs[i].vs;
      end else begin
        idle();
      end
    end

    // First tick only leaves INIT; the second moves by speed 2.
    speed_a = 3'd2;
    tick();
    check_box_a("init_tick", 304, 224);
    check("init_tick.state", 32'(dut_a.state_q), 32'(StRun));
    tick();
    check_box_a("run_tick", 306, 226);
    check("run_tick.idx", 32'(dut_a.pal_idx_q), 32'h0);
    check_box_b("b_speed0", 606, 288, DirPos, DirPos, 0);

    // Pause raised mid-frame: the next tick still moves, then motion freezes.
    @(posedge clk); #1;
    hpos = 10'd10; vpos = 10'd100; pause_a = 1'b1;
    @(posedge clk); #1;
    check("pause_mid.state", 32'(dut_a.state_q), 32'(StRun));
    idle();
    tick();
    check_box_a("pause_tick", 308, 228);
    check("pause_tick.state", 32'(dut_a.state_q), 32'(StHold));
    for (int i = 0; i < 3; i++) begin
      tick();
      check_box_a($sformatf("held%0d", i), 308, 228);
    end
    pause_a = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("unpause_mid.state", 32'(dut_a.state_q), 32'(StHold));
    tick();
    check("unpause_tick.state", 32'(dut_a.state_q), 32'(StRun));
    tick();
    check_box_a("resumed", 310, 230);
    speed_a = 3'd0;

    // Right-edge bounce: 606+4 > 608 clamps and turns left.
    ticks_b(1, 3'd4);
    check_box_b("edge", 608, 292, DirNeg, DirPos, 1);
    // Walk to (448,448) with y clamping on the last step.
    ticks_b(22, 3'd7);
    ticks_b(1, 3'd6);
    check_box_b("y_edge", 448, 448, DirNeg, DirNeg, 2);
    // Walk to (0,0) moving negative, then hit the corner.
    ticks_b(63, 3'd7);
    ticks_b(1, 3'd4);
    ticks_b(1, 3'd3);
    check_box_b("at_origin", 0, 0, DirNeg, DirNeg, 2);
    ticks_b(1, 3'd3);
    check_box_b("corner", 0, 0, DirPos, DirPos, 3);
    check_box_a("a_static", 310, 230);
    speed_b = 3'd0;

    // Corner colour is palette entry 3.
    @(posedge clk); #1;
    hpos = 10'd0; vpos = 10'd0; de = 1'b1;
    @(posedge clk); #1;
    hpos = 10'd32;
    @(posedge clk); #1;
    check("corner_pix.in", 32'(rgb_b), 32'(ExpPal3));
    idle();
    @(posedge clk); #1;
    check("corner_pix.out", 32'(rgb_b), 32'(ExpBg));

    // Asynchronous reset mid-frame at (320,200).
    hpos = 10'd320; vpos = 10'd200; de = 1'b1; hs_n = 1'b0; vs_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst.rgb", 32'(rgb_a), 32'(ExpBg));
    check("pre_rst.hs",  32'(hs_a),  32'h0);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst.rgb", 32'(rgb_a), 32'h0);
    check("async_rst.hs",  32'(hs_a),  32'h1);
    check("async_rst.vs",  32'(vs_a),  32'h1);
    check_box_a("async_rst", 304, 224);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    speed_a = 3'd2;
    repeat (4) @(posedge clk);
    #1;
    check_box_a("post_rst", 304, 224);
    check("post_rst.state", 32'(dut_a.state_q), 32'(StInit));
    idle();
    tick();
    check_box_a("post_rst_tick1", 304, 224);
    tick();
    check_box_a("post_rst_tick2", 306, 226);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/bounce_box_gen.md
BOUNCE_BOX_GEN -- requirements
Module: bounce_box_gen

Interface
REQ-001 The module SHALL provide parameter BOX_SIZE, default 32, meaning the box edge length in pixels (legal range 1..64).
REQ-002 The module SHALL provide parameter X0, default 304, meaning the box left edge after reset.
REQ-003 The module SHALL provide parameter Y0, default 224, meaning the box top edge after reset.
REQ-004 clk_i  input  1  pixel clock, the same clock that drives the sync generator; single clock domain.
REQ-005 reset_i  input  1  asynchronous, active-high reset.
REQ-006 hsync_ni  input  1  active-low horizontal sync from the sync generator.
REQ-007 vsync_ni  input  1  active-low vertical sync from the sync generator.
REQ-008 display_enable_i  input  1  high inside the visible 640x480 area.
REQ-009 hpos_i  input  10  current pixel column, 0..799.
REQ-010 vpos_i  input  10  current line, 0..524.
REQ-011 pause_i  input  1  level; when high, the box motion freezes.
REQ-012 speed_i  input  3  step in pixels per frame on each axis, 0..7.
REQ-013 hsync_no, vsync_no  output  1 each  active-low syncs, aligned to rgb_o.
REQ-014 rgb_o  output  12  pixel colour, 4:4:4 RGB.

Function
REQ-015 The module SHALL generate a frame tick when vpos_i==480 and hpos_i==0, i.e. once per frame, at the first blanking line.
REQ-016 The FSM SHALL have three states: INIT (after reset), RUN and HOLD.
- INIT -> RUN on the first frame tick.
- RUN -> HOLD on a frame tick with pause_i=1.
- HOLD -> RUN on a frame tick with pause_i=0.
REQ-017 pause_i SHALL be sampled only at the frame tick; a change mid-frame SHALL take effect at the next tick.
REQ-018 Box position (box_x, box_y, 10 bits each) and direction (dir_x, dir_y) SHALL update only at a frame tick while in RUN; speed_i SHALL be sampled at that same tick.
REQ-019 X axis, moving right: if box_x + speed > 640-BOX_SIZE, box_x SHALL clamp to 640-BOX_SIZE and dir_x SHALL flip to left; otherwise box_x += speed.
REQ-020 X axis, moving left: if box_x < speed, box_x SHALL clamp to 0 and dir_x SHALL flip to right; otherwise box_x -= speed.
REQ-021 Y axis SHALL follow the same rules as X, with bound 480-BOX_SIZE.
REQ-022 All position arithmetic SHALL use 11-bit intermediates so that no wrap-around occurs.
REQ-023 speed=0 SHALL leave position and direction unchanged.
REQ-024 Each bounce SHALL advance a 3-bit palette index (wrapping 7->0). A corner hit (both axes bounce at the same tick) SHALL advance it by exactly one.
REQ-025 A pixel SHALL be inside the box when box_x <= hpos < box_x+BOX_SIZE and box_y <= vpos < box_y+BOX_SIZE.
REQ-026 rgb_o SHALL be:
- palette[index] when display enable is high and the pixel is inside the box;
- 12'h111 (background) when display enable is high and the pixel is outside the box;
- 0 when display enable is low.
REQ-027 Pipeline: stage 1 SHALL register the inside-box compare, display enable and syncs; stage 2 SHALL register the colour mux. rgb_o, hsync_no and vsync_no SHALL each lag their inputs by exactly 2 cycles.
REQ-028 Position updates occur in vertical blanking, so a visible frame SHALL never show a partially moved box.

Reset
REQ-029 While reset_i is high, the outputs SHALL be: rgb_o=0, hsync_no=1, vsync_no=1, and both pipeline stages SHALL be cleared to the same inactive values.
REQ-030 While reset_i is high, the internal state SHALL be: state=INIT, box_x=X0, box_y=Y0, dir_x=right, dir_y=down, palette index=0.
REQ-031 Reset asserted mid-frame SHALL take effect immediately and asynchronously; after release, motion SHALL resume only after the next frame tick.

Structure
REQ-032 Shared package vga_pkg SHALL hold:
- H_DISPLAY=640 and V_DISPLAY=480;
- the rgb_t typedef (12 bits);
- the 8-entry palette constant;
- the FSM state enum.
REQ-033 Sub-module pipe_delay, parameterised on WIDTH and DEPTH with async reset and a reset value, SHALL delay {hsync_ni, vsync_ni} by 2 cycles; each delayed line SHALL reset to 1 (inactive).
REQ-034 The expected RTL size is 150-300 lines.

Verification
REQ-035 Reset then one frame tick with speed=2 and pause=0: at the next tick box_x SHALL go 304->306 and box_y 224->226; no colour change.
REQ-036 Right-edge bounce: box_x=606, speed=4, moving right: next tick box_x SHALL be 608, direction left, palette index +1.
REQ-037 Corner bounce: box_x=0, box_y=0, both moving negative, speed=3: next tick SHALL give (0,0), both directions positive, index +1 only.
REQ-038 Pixel checks with box at (100,50), BOX_SIZE 32, index 0:
- hpos=100, vpos=50 -> rgb_o SHALL equal palette[0] exactly 2 cycles later;
- hpos=132 -> rgb_o SHALL equal 12'h111;
- blanking -> rgb_o SHALL equal 0.
REQ-039 pause_i raised mid-frame: position SHALL keep changing at the current tick, then stay frozen across 3 following ticks. After pause_i drops, motion SHALL resume at the first tick that samples pause_i=0.
REQ-040 Reset asserted at hpos=320, vpos=200: rgb_o=0 and syncs=1 SHALL appear in the same cycle; after release, the box SHALL be at (X0,Y0) and static until the first frame tick.
